imem_loader: RTL

Boot-time program loader that writes the instruction memory the single-cycle core fetches from. It consumes a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and issues one word write per instruction to consecutive word addresses starting at 0. It checks a trailing XOR checksum and holds the core in its hold state until a load completes cleanly. It sits beside the top level, and its write port drives the instruction memory write side.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/word_assembler.sv | 36 +++
 rtl/imem_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared loader types and constants.
// Used by the instruction memory boot loader.
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERR
    } loader_state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int CHK_W          = 8;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);
    localparam int LEN_W          = 8 * LEN_BYTES;

    // Running XOR checksum step.
    function automatic logic [CHK_W-1:0] chk_fold(
        input logic [CHK_W-1:0] acc,
        input logic [7:0]       b
    );
        return acc ^ b;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word shifter.
// word_valid flags the byte that completes a word.
module word_assembler
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam int HI_W = 8 * (BYTES_PER_WORD - 1);

    logic [LANE_W-1:0] lane;
    logic [HI_W-1:0]   hi;

    // The incoming byte is the least significant lane of the word.
    assign word       = {hi, byte_in};
    assign word_valid = shift_en
                     && (lane == LANE_W'(BYTES_PER_WORD - 1));

    // Lane counter and upper-byte shift register.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            lane <= '0;
            hi   <= '0;
        end else if (shift_en) begin
            lane <= lane + 1'b1;
            hi   <= {hi[HI_W-9:0], byte_in};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream to instruction memory.
// Holds the core until a checksummed load completes.
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    localparam logic [LEN_W:0] CAP = (LEN_W+1)'(1) << ADDR_W;

    loader_state_t     state;
    logic [7:0]        len_hi;
    logic [LEN_W-1:0]  n_words;
    logic [ADDR_W:0]   widx;
    logic [ADDR_W:0]   widx_next;
    logic [CHK_W-1:0]  acc;
    logic [LEN_W-1:0]  len_now;
    logic              xfer;
    logic              idle_like;
    logic              asm_clr;
    logic              asm_shift;
    logic [31:0]       asm_word;
    logic              asm_valid;
    logic              last_word;

    assign xfer      = byte_valid && byte_ready;
    assign len_now   = {len_hi, byte_in};
    assign widx_next = widx + 1'b1;
    assign last_word = (LEN_W+1)'(widx_next)
                    == (LEN_W+1)'(n_words);
    assign idle_like = (state == IDLE)
                    || (state == DONE)
                    || (state == ERR);
    assign asm_clr   = start && idle_like;
    assign asm_shift = xfer && (state == DATA);

    word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (asm_clr),
        .shift_en   (asm_shift),
        .byte_in    (byte_in),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    // Loader FSM with registered handshake, write and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_hi     <= '0;
            n_words    <= '0;
            widx       <= '0;
            acc        <= '0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wd    <= '0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= LEN_HI;
                        len_hi     <= '0;
                        n_words    <= '0;
                        widx       <= '0;
                        acc        <= '0;
                        byte_ready <= 1'b1;
                        core_hold  <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_hi <= byte_in;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        n_words <= len_now;
                        if ((LEN_W+1)'(len_now) > CAP) begin
                            state      <= ERR;
                            error      <= 1'b1;
                            byte_ready <= 1'b0;
                        end else if (len_now == '0) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (asm_shift) begin
                        acc <= chk_fold(acc, byte_in);
                        if (asm_valid) begin
                            imem_we   <= 1'b1;
                            imem_addr <= widx[ADDR_W-1:0];
                            imem_wd   <= asm_word;
                            widx      <= widx_next;
                            if (last_word) begin
                                state <= CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        byte_ready <= 1'b0;
                        if (byte_in == acc) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
